// File: rtl/enc_stage_2.sv
// Stage 2 of the extended Hamming encoder: folds the overall parity into the
// codeword, drops illegal-mode words and buffers the results in a small FIFO.
module enc_stage_2 #(
    parameter int MAX_CODEWORD_WIDTH = 32,
    parameter int FIFO_DEPTH         = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [MAX_CODEWORD_WIDTH-1:0] data_in,
    input  logic [1:0]                    work_mod,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic [MAX_CODEWORD_WIDTH-1:0] data_out,
    output logic [1:0]                    mod_out,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [7:0]                    drop_cnt
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int IDX_W = $clog2(MAX_CODEWORD_WIDTH);

    logic [MAX_CODEWORD_WIDTH-1:0] mem_data [FIFO_DEPTH];
    logic [1:0]                    mem_mod  [FIFO_DEPTH];
    logic [PTR_W-1:0]              wr_ptr;
    logic [PTR_W-1:0]              rd_ptr;
    logic [CNT_W-1:0]              count;

    logic [MAX_CODEWORD_WIDTH-1:0] keep_mask;
    logic [MAX_CODEWORD_WIDTH-1:0] masked_word;
    logic [MAX_CODEWORD_WIDTH-1:0] enc_word;
    logic [IDX_W-1:0]              par_pos;
    logic                          overall_par;
    int                            n_bits;
    logic                          accept;
    logic                          push;
    logic                          drop;
    logic                          pop;

    // The parity position is the top parity bit of each mode, which stage 1 leaves at zero.
    always_comb begin
        n_bits  = 8;
        par_pos = IDX_W'(3);
        case (work_mod)
            2'b01: begin
                n_bits  = 16;
                par_pos = IDX_W'(4);
            end
            2'b10: begin
                n_bits  = 32;
                par_pos = IDX_W'(5);
            end
            default: begin
                n_bits  = 8;
                par_pos = IDX_W'(3);
            end
        endcase
        keep_mask = '0;
        for (int i = 0; i < MAX_CODEWORD_WIDTH; i++) begin
            keep_mask[i] = (i < n_bits);
        end
        masked_word       = data_in & keep_mask;
        overall_par       = ^masked_word;
        enc_word          = masked_word;
        enc_word[par_pos] = overall_par;
    end

    assign in_ready  = (count < CNT_W'(FIFO_DEPTH));
    assign out_valid = (count != '0);
    assign accept    = in_valid && in_ready;
    assign push      = accept && (work_mod != 2'b11);
    assign drop      = accept && (work_mod == 2'b11);
    assign pop       = out_valid && out_ready;
    assign data_out  = out_valid ? mem_data[rd_ptr] : '0;
    assign mod_out   = out_valid ? mem_mod[rd_ptr]  : 2'b00;

    always_ff @(posedge clk) begin
        if (!rst) begin
            count    <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            drop_cnt <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(push) - CNT_W'(pop);
            if (drop && (drop_cnt != 8'hFF)) begin
                drop_cnt <= drop_cnt + 8'd1;
            end
        end
    end

    // Storage needs no reset: the occupancy count alone decides what is visible.
    always_ff @(posedge clk) begin
        if (push && rst) begin
            mem_data[wr_ptr] <= enc_word;
            mem_mod[wr_ptr]  <= work_mod;
        end
    end

endmodule

// File: tb/tb_enc_stage_2.sv
// Self-checking bench for enc_stage_2: table vectors, corner sequences and random traffic
// against a queue-based reference model.
module tb_enc_stage_2;

    localparam int W     = 32;
    localparam int DEPTH = 4;

    logic          clk;
    logic          rst;
    logic [W-1:0]  data_in;
    logic [1:0]    work_mod;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  data_out;
    logic [1:0]    mod_out;
    logic          out_valid;
    logic          out_ready;
    logic [7:0]    drop_cnt;

    enc_stage_2 #(.MAX_CODEWORD_WIDTH(W), .FIFO_DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .data_in   (data_in),
        .work_mod  (work_mod),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .data_out  (data_out),
        .mod_out   (mod_out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .drop_cnt  (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] d;
        logic [1:0]   m;
    } entry_t;

    typedef struct {
        logic [W-1:0] din;
        logic [1:0]   mode;
        logic [W-1:0] expected;
    } vec_t;

    entry_t model_q[$];
    int     model_drops;
    int     checks;
    int     errors;

    function automatic logic [W-1:0] refEncode(input logic [W-1:0] d, input logic [1:0] m);
        int          n;
        int          p;
        logic [63:0] w;
        n = 8 << m;
        p = 4 + int'(m);
        w = {32'b0, d} & ((64'd1 << n) - 64'd1);
        w[p-1] = 1'b0;
        w[p-1] = ((($countones({32'b0, d} & ((64'd1 << n) - 64'd1))) % 2) == 1);
        return w[W-1:0];
    endfunction

    task automatic checkVal(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic checkOutput(input string tag);
        logic [W-1:0] exp_data;
        logic [1:0]   exp_mod;
        exp_data = '0;
        exp_mod  = 2'b00;
        if (model_q.size() != 0) begin
            exp_data = model_q[0].d;
            exp_mod  = model_q[0].m;
        end
        checkVal({tag, ".out_valid"}, W'(out_valid), W'(model_q.size() != 0));
        checkVal({tag, ".data_out"}, data_out, exp_data);
        checkVal({tag, ".mod_out"}, W'(mod_out), W'(exp_mod));
        checkVal({tag, ".in_ready"}, W'(in_ready), W'(model_q.size() < DEPTH));
        checkVal({tag, ".drop_cnt"}, W'(drop_cnt), W'(model_drops));
    endtask

    // Drives one cycle of inputs, advances the model across the edge and checks the result.
    task automatic applyStimulus(input logic v, input logic [W-1:0] d, input logic [1:0] m,
                                 input logic ordy, input logic rstv, input string tag,
                                 output logic accepted);
        logic pop_now;
        rst       = rstv;
        in_valid  = v;
        data_in   = d;
        work_mod  = m;
        out_ready = ordy;
        accepted  = v && (model_q.size() < DEPTH) && rstv;
        pop_now   = (model_q.size() != 0) && ordy && rstv;
        @(posedge clk);
        #1;
        if (!rstv) begin
            model_q.delete();
            model_drops = 0;
        end else begin
            if (pop_now) void'(model_q.pop_front());
            if (accepted) begin
                if (m == 2'b11) begin
                    if (model_drops < 255) model_drops++;
                end else begin
                    model_q.push_back('{d: refEncode(d, m), m: m});
                end
            end
        end
        checkOutput(tag);
    endtask

    vec_t   vecs[8];
    logic   acc;
    int     tries;

    initial begin
        checks      = 0;
        errors      = 0;
        model_drops = 0;
        rst         = 1'b0;
        in_valid    = 1'b0;
        data_in     = '0;
        work_mod    = 2'b00;
        out_ready   = 1'b0;

        vecs[0] = '{32'h0000_0013, 2'b00, 32'h0000_001B};
        vecs[1] = '{32'h0000_0001, 2'b01, 32'h0000_0011};
        vecs[2] = '{32'h0000_0001, 2'b10, 32'h0000_0021};
        vecs[3] = '{32'hFFFF_FF00, 2'b00, 32'h0000_0000};
        vecs[4] = '{32'h0000_000F, 2'b00, 32'h0000_0007};
        vecs[5] = '{32'h0000_07EF, 2'b01, 32'h0000_07EF};
        vecs[6] = '{32'hFFFF_FFDF, 2'b10, 32'hFFFF_FFFF};
        vecs[7] = '{32'h1234_5600, 2'b01, 32'h0000_5600};

        applyStimulus(1'b1, 32'hA5, 2'b00, 1'b1, 1'b0, "reset0", acc);
        applyStimulus(1'b0, '0, 2'b00, 1'b0, 1'b0, "reset1", acc);

        // Streaming table: each new word replaces the previous head in the same cycle.
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, vecs[i].din, vecs[i].mode, 1'b1, 1'b1, $sformatf("vec%0d", i), acc);
            checkVal($sformatf("vec%0d.table", i), data_out, vecs[i].expected);
            checkVal($sformatf("vec%0d.mode", i), W'(mod_out), W'(vecs[i].mode));
        end
        applyStimulus(1'b0, '0, 2'b00, 1'b1, 1'b1, "drain", acc);

        // Fill with the consumer stalled; the fifth word must wait.
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, W'(32'h100 + i), 2'(i % 3), 1'b0, 1'b1, $sformatf("fill%0d", i), acc);
        end
        checkVal("full.in_ready", W'(in_ready), W'(0));
        tries = 0;
        acc   = 1'b0;
        while (!acc && tries < 20) begin
            applyStimulus(1'b1, W'(32'h104), 2'b01, 1'b1, 1'b1, "held5", acc);
            tries++;
        end
        if (!acc) begin
            checks++;
            errors++;
            $display("[TB] FAIL held5.timeout: got not accepted, expected accepted");
        end
        for (int i = 0; i < 6; i++) applyStimulus(1'b0, '0, 2'b00, 1'b1, 1'b1, "drain5", acc);

        // One entry resident, then push and pop together.
        applyStimulus(1'b1, 32'h0000_0003, 2'b00, 1'b0, 1'b1, "one", acc);
        applyStimulus(1'b1, 32'h0000_0005, 2'b00, 1'b1, 1'b1, "pushpop", acc);
        checkVal("pushpop.data", data_out, 32'h0000_0005);
        applyStimulus(1'b0, '0, 2'b00, 1'b1, 1'b1, "pushpop.drain", acc);
        checkVal("pushpop.empty", W'(out_valid), W'(0));

        // Illegal mode words are counted and discarded.
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, W'($urandom), 2'b11, 1'b1, 1'b1, "illegal", acc);
        checkVal("illegal.drop3", W'(drop_cnt), W'(3));
        checkVal("illegal.nodata", W'(out_valid), W'(0));
        for (int i = 0; i < 256; i++) applyStimulus(1'b1, W'($urandom), 2'b11, 1'b0, 1'b1, "sat", acc);
        checkVal("illegal.sat", W'(drop_cnt), W'(255));

        // Reset in the middle of buffered traffic.
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, W'(32'h20 + i), 2'b00, 1'b0, 1'b1, "prefill", acc);
        applyStimulus(1'b1, 32'h77, 2'b00, 1'b0, 1'b0, "midreset", acc);
        checkVal("midreset.valid", W'(out_valid), W'(0));
        checkVal("midreset.drop", W'(drop_cnt), W'(0));
        checkVal("midreset.ready", W'(in_ready), W'(1));
        applyStimulus(1'b1, 32'h0000_0013, 2'b00, 1'b0, 1'b1, "postreset", acc);
        checkVal("postreset.data", data_out, 32'h0000_001B);
        applyStimulus(1'b0, '0, 2'b00, 1'b1, 1'b1, "postreset.pop", acc);
        checkVal("postreset.only", W'(out_valid), W'(0));

        // Random traffic with occasional illegal modes and resets.
        for (int i = 0; i < 400; i++) begin
            logic [1:0] m;
            m = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            applyStimulus(1'($urandom_range(0, 3) != 0), W'($urandom), m,
                          1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 49) != 0),
                          "rand", acc);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/enc_stage_2.md
ENC_STAGE_2 -- requirements
Module: enc_stage_2

Interface
REQ-001 The module SHALL have parameter MAX_CODEWORD_WIDTH, default 32, meaning the width of the codeword bus.
REQ-002 The module SHALL have parameter FIFO_DEPTH, default 4 (power of two, at least 2), meaning the number of output buffer entries.
REQ-003 Port clk  input  1  is the single clock; all state SHALL update on its rising edge.
REQ-004 Port rst  input  1  is the reset: synchronous, active-low.
REQ-005 Port data_in  input  MAX_CODEWORD_WIDTH  is the stage-1 codeword {zero pad, info, parity}; its top parity bit is 0.
REQ-006 Port work_mod  input  2  is the mode of data_in: 00 = 4 info/4 parity, 01 = 11/5, 10 = 26/6, 11 = illegal.
REQ-007 Port in_valid  input  1  SHALL mean data_in/work_mod are valid.
REQ-008 Port in_ready  output  1  SHALL mean the block accepts a word this cycle.
REQ-009 Port data_out  output  MAX_CODEWORD_WIDTH  is the completed extended codeword at the FIFO head.
REQ-010 Port mod_out  output  2  is the mode of the head entry.
REQ-011 Port out_valid  output  1  SHALL mean the head entry is valid.
REQ-012 Port out_ready  input  1  SHALL mean the consumer takes the head entry.
REQ-013 Port drop_cnt  output  8  is a saturating count of illegal-mode words dropped.

Function
REQ-014 A word SHALL be accepted when in_valid and in_ready are both 1 in the same cycle.
REQ-015 For accepted mode m, let P = 4/5/6 and N = 8/16/32 (info + parity); overall parity = XOR of data_in[N-1:0].
REQ-016 The stored word SHALL equal data_in[N-1:0] with bit P-1 replaced by the overall parity, and bits [MAX_CODEWORD_WIDTH-1:N] forced to 0.
REQ-017 Accepted words SHALL be written to the FIFO at the clock edge of acceptance, with mod_out stored alongside.
REQ-018 A written word SHALL be visible on data_out with out_valid = 1 in the cycle after acceptance (1-cycle latency when the FIFO was empty).
REQ-019 out_valid SHALL be 1 iff the occupancy count is nonzero.
REQ-020 data_out and mod_out SHALL be the head entry, and SHALL be all-zero when the FIFO is empty.
REQ-021 A pop SHALL occur when out_valid and out_ready are both 1; pops SHALL advance the read pointer.
REQ-022 in_ready SHALL be 1 iff count < FIFO_DEPTH; there is no same-cycle pass-through when full, even if out_ready = 1.
REQ-023 A simultaneous push and pop SHALL leave count unchanged and preserve FIFO order.
REQ-024 Read and write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-025 An accepted work_mod = 11 word SHALL NOT be written; drop_cnt SHALL increment by 1 and saturate at 255.
REQ-026 in_ready SHALL apply to illegal-mode words as to any other word (a full FIFO stalls them too).
REQ-027 Words SHALL leave the block in acceptance order, with no loss and no duplication.

Reset
REQ-028 While rst = 0 at a clock edge: count, both pointers and drop_cnt SHALL clear to 0, so that out_valid = 0, data_out = 0, mod_out = 0 and in_ready = 1 (FIFO_DEPTH > 0) from the next cycle.
REQ-029 A reset mid-operation SHALL discard all buffered words; any word presented in a reset cycle SHALL NOT be accepted.

Verification
REQ-030 Mode 00, data_in = 0x00000013, out_ready = 1 -> next cycle data_out = 0x0000001B, mod_out = 00, out_valid = 1.
REQ-031 Mode 01, data_in = 0x00000001 -> data_out = 0x00000011; mode 10, data_in = 0x00000001 -> data_out = 0x00000021; mode 00, data_in = 0xFFFFFF00 -> data_out = 0x00000000.
REQ-032 out_ready = 0, push 5 words on consecutive cycles -> in_ready = 0 after the 4th; the 5th is held; then assert out_ready -> the 4 words are popped in order, then the 5th is accepted and output.
REQ-033 Count = 1 with simultaneous push and pop -> count stays 1; the next data_out is the pushed word.
REQ-034 Three words with work_mod = 11 -> drop_cnt = 3, out_valid remains 0; after 256 such words drop_cnt = 255.
REQ-035 Fill 3 entries, assert rst = 0 for one cycle -> out_valid = 0, drop_cnt = 0, in_ready = 1; a subsequent push produces only the new word.
